// File: rtl/conv1d_mac_seq.sv
// Sequencer driving a single MAC through a 1-D valid convolution, y[j] = sum_k x[j+k]*f[k].
// Emits each y[j] on a valid/ready stream and pulses done after the last handshake.
module conv1d_mac_seq #(
  parameter int unsigned N  = 43,
  parameter int unsigned M  = 16,
  parameter int unsigned T  = 32,
  parameter int unsigned XA = $clog2(N),
  parameter int unsigned FA = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [XA-1:0] x_addr,
  output logic [FA-1:0] f_addr,
  output logic          en_mult_reg,
  output logic          en_adder_reg,
  output logic          reset_accum,
  input  logic [T-1:0]  accum_in,
  output logic [T-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam logic [XA-1:0] J_LAST = XA'(N - M);
  localparam logic [FA-1:0] K_LAST = FA'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN1,
    S_DRAIN2,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XA-1:0]   r_j;
  logic [FA-1:0]   r_k;
  logic            r_en_mult;
  logic            r_en_add;
  logic [T-1:0]    r_m_data;
  logic            r_m_valid;
  logic            r_done;

  logic            w_out_free;
  logic            w_rd_en;
  logic            w_load;
  logic            w_rst_acc;
  logic            w_done_set;

  // Output register can take a new sample when empty or being drained this cycle.
  assign w_out_free = ~r_m_valid | m_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_ISSUE;
      S_ISSUE:   if (r_k == K_LAST) w_next = S_DRAIN1;
      S_DRAIN1:  w_next = S_DRAIN2;
      S_DRAIN2:  w_next = S_CAPTURE;
      S_CAPTURE: if (w_out_free) w_next = (r_j == J_LAST) ? S_FINISH : S_ISSUE;
      S_FINISH:  if (w_out_free) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en    = 1'b0;
    w_load     = 1'b0;
    w_rst_acc  = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      S_IDLE:    w_rst_acc = start;
      S_ISSUE:   w_rd_en = 1'b1;
      S_CAPTURE: begin
        w_load    = w_out_free;
        w_rst_acc = w_out_free;
      end
      S_FINISH:  w_done_set = w_out_free;
      default:   ;
    endcase
  end

  // Counters, MAC strobe pipeline and output stream register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_j       <= '0;
      r_k       <= '0;
      r_en_mult <= 1'b0;
      r_en_add  <= 1'b0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_en_mult <= w_rd_en;
      r_en_add  <= r_en_mult;
      r_done    <= w_done_set;
      if (r_state == S_IDLE && start) begin
        r_j <= '0;
        r_k <= '0;
      end else if (w_rd_en) begin
        r_k <= (r_k == K_LAST) ? '0 : r_k + FA'(1);
      end else if (w_load && r_j != J_LAST) begin
        r_j <= r_j + XA'(1);
      end
      if (w_load) begin
        r_m_data  <= accum_in;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign mem_rd_en    = w_rd_en;
  assign x_addr       = w_rd_en ? (r_j + XA'(r_k)) : '0;
  assign f_addr       = w_rd_en ? r_k : '0;
  assign en_mult_reg  = r_en_mult;
  assign en_adder_reg = r_en_add;
  assign reset_accum  = w_rst_acc;
  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;

endmodule

// File: tb/tb_conv1d_mac_seq.sv
// Bench for conv1d_mac_seq: drives it with a saturating/ReLU MAC and two sync-read memories,
// and checks streamed results against a direct convolution computed from the memory contents.
module tb_conv1d_mac_seq;

  localparam int unsigned N  = 43;
  localparam int unsigned M  = 16;
  localparam int unsigned T  = 32;
  localparam int unsigned XA = $clog2(N);
  localparam int unsigned FA = $clog2(M);
  localparam int NY    = N - M + 1;
  localparam int LIMIT = 2500;

  localparam int MD_NORM = 0;
  localparam int MD_BP   = 1;
  localparam int MD_RST  = 2;
  localparam int MD_HOLD = 3;
  localparam int MD_RAND = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [XA-1:0] x_addr;
  logic [FA-1:0] f_addr;
  logic          en_mult_reg;
  logic          en_adder_reg;
  logic          reset_accum;
  logic [T-1:0]  accum_in;
  logic [T-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;

  conv1d_mac_seq #(.N(N), .M(M), .T(T), .XA(XA), .FA(FA)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .x_addr(x_addr), .f_addr(f_addr),
    .en_mult_reg(en_mult_reg), .en_adder_reg(en_adder_reg), .reset_accum(reset_accum),
    .accum_in(accum_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sat(input longint s);
    if (s > 64'sd2147483647)  return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  // Memories and MAC surrounding the sequencer.
  logic signed [T-1:0] xmem [N];
  logic signed [T-1:0] fmem [M];
  logic signed [T-1:0] r_xd, r_fd;
  longint              r_prod, r_acc;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      r_xd <= xmem[x_addr];
      r_fd <= fmem[f_addr];
    end
    if (reset) begin
      r_prod <= 0;
      r_acc  <= 0;
    end else begin
      if (en_mult_reg) r_prod <= longint'(r_xd) * longint'(r_fd);
      if (reset_accum)       r_acc <= 0;
      else if (en_adder_reg) r_acc <= sat(r_acc + r_prod);
    end
  end
  assign accum_in = (r_acc < 0) ? '0 : T'(r_acc);

  wire [48:0] w_outs = {busy, done, mem_rd_en, x_addr, f_addr, en_mult_reg,
                        en_adder_reg, reset_accum, m_data, m_valid};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: direct convolution with the MAC's per-step saturation and final ReLU.
  longint yref [NY];
  function automatic void build_ref();
    for (int j = 0; j < NY; j++) begin
      longint a = 0;
      for (int k = 0; k < M; k++) a = sat(a + longint'(xmem[j+k]) * longint'(fmem[k]));
      yref[j] = (a < 0) ? 0 : a;
    end
  endfunction

  function automatic void load_ramp();
    for (int i = 0; i < N; i++) xmem[i] = T'(i);
    for (int k = 0; k < M; k++) fmem[k] = 1;
  endfunction

  longint got [$];
  int     vcyc [$];
  int     done_cyc, done_cnt, rd_bp, bad_hold, max_xa;

  task automatic run_conv(input int mode);
    bit prev_v;
    bit fin;
    got.delete(); vcyc.delete();
    done_cyc = -1; done_cnt = 0; rd_bp = 0; bad_hold = 0; max_xa = 0;
    prev_v = 1'b0; fin = 1'b0;
    @(negedge clk); start = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= LIMIT && !fin; c++) begin
      @(negedge clk);
      if (mode != MD_HOLD) start = 1'b0;
      case (mode)
        MD_BP:   m_ready = !(c >= 20 && c < 70);
        MD_RAND: m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
      if (mode == MD_HOLD && done_cyc >= 0) begin
        chk("restart_after_done", longint'(busy), 1);
        fin = 1'b1;
      end else begin
        if (m_valid && !prev_v) vcyc.push_back(c);
        prev_v = m_valid;
        if (m_valid && m_ready) got.push_back(longint'(m_data));
        if (done) begin
          done_cnt++;
          done_cyc = c;
          chk("busy_at_done", longint'(busy), 0);
        end
        if (mem_rd_en && int'(x_addr) > max_xa) max_xa = int'(x_addr);
        if (mode == MD_BP && c >= 20 && c < 70) begin
          if (mem_rd_en) rd_bp++;
          if (m_data != T'(120) || !m_valid) bad_hold++;
        end
        if (mode == MD_BP && c == 65)
          chk("bp_stall", longint'({busy, mem_rd_en, en_mult_reg, en_adder_reg, m_valid}), 5'b10001);
        if (mode == MD_RST && c == 100) reset = 1'b1;
        if (mode == MD_RST && c == 101) begin
          chk("rst_abort_outputs", longint'(w_outs), 0);
          reset = 1'b0;
          fin = 1'b1;
        end
        if (done && mode != MD_HOLD) fin = 1'b1;
      end
    end
    if (!fin) chk("run_timeout", 0, 1);
    start = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk($sformatf("%s_count", tag), got.size(), NY);
    for (int i = 0; i < got.size() && i < NY; i++)
      chk($sformatf("%s_y%0d", tag, i), got[i], yref[i]);
  endtask

  task automatic check_ramp_timing(input string tag);
    chk($sformatf("%s_nvalid", tag), vcyc.size(), NY);
    if (vcyc.size() == NY) begin
      chk($sformatf("%s_first_valid", tag), vcyc[0], 20);
      chk($sformatf("%s_second_valid", tag), vcyc[1], 39);
      chk($sformatf("%s_last_valid", tag), vcyc[NY-1], 533);
    end
    if (got.size() == NY) begin
      chk($sformatf("%s_y0", tag), got[0], 120);
      chk($sformatf("%s_ylast", tag), got[NY-1], 552);
    end
    chk($sformatf("%s_done_cycle", tag), done_cyc, 534);
    chk($sformatf("%s_done_count", tag), done_cnt, 1);
    chk($sformatf("%s_max_xaddr", tag), max_xa, N - 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; m_ready = 1'b0;
    load_ramp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", longint'(w_outs), 0);
    reset = 1'b0;

    // Ramp with an always-ready consumer.
    load_ramp(); build_ref();
    run_conv(MD_NORM);
    check_outputs("ramp");
    check_ramp_timing("ramp");

    // Every sum negative: ReLU zeroes all outputs.
    for (int i = 0; i < N; i++) xmem[i] = 1;
    for (int k = 0; k < M; k++) fmem[k] = -1;
    build_ref();
    run_conv(MD_NORM);
    check_outputs("neg");
    chk("neg_nvalid", vcyc.size(), NY);
    chk("neg_done_count", done_cnt, 1);

    // Consumer stalls for 50 cycles right after the first result.
    load_ramp(); build_ref();
    run_conv(MD_BP);
    check_outputs("bp");
    chk("bp_bursts", rd_bp, M);
    chk("bp_hold_bad", bad_hold, 0);

    // Products overflow the result width: accumulator saturates.
    for (int i = 0; i < N; i++) xmem[i] = (i < 16) ? 32'sh4000_0000 : 0;
    for (int k = 0; k < M; k++) fmem[k] = 4;
    build_ref();
    run_conv(MD_NORM);
    check_outputs("sat");
    if (got.size() > 0) chk("sat_y0", got[0], 2147483647);

    // Reset mid-run, then a clean rerun of the ramp.
    load_ramp(); build_ref();
    run_conv(MD_RST);
    chk("rst_done_count", done_cnt, 0);
    chk("rst_outputs_before", got.size(), 5);
    run_conv(MD_NORM);
    check_outputs("rerun");
    check_ramp_timing("rerun");

    // start held high: one full run, next begins only after done.
    run_conv(MD_HOLD);
    check_outputs("hold");
    chk("hold_done_count", done_cnt, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("hold_reset_outputs", longint'(w_outs), 0);
    reset = 1'b0;

    // Random data with random consumer backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) xmem[i] = T'(int'($urandom_range(0, 200)) - 100);
      for (int k = 0; k < M; k++) fmem[k] = T'(int'($urandom_range(0, 60)) - 30);
      build_ref();
      run_conv(MD_RAND);
      check_outputs($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_done_count", r), done_cnt, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
